// File: rtl/mem_byte_responder.sv
// mem_byte_responder
//   Serializes 1/2/4-byte CPU memory requests onto an 8-bit external RAM/IO
//   bus, one byte per cycle. Read bytes are assembled little-endian and
//   zero-extended into a 32-bit result. The memory returns data one cycle
//   after the address is driven, so reads run as a one-deep pipeline.
//
// Ports
//   clk_in          system clock, rising edge
//   rst_n_in        asynchronous active-low reset
//   rdy_in          global ready; the block is frozen while low
//   mem_din         byte returned for the address driven in the previous cycle
//   mem_dout        write byte
//   mem_a           byte address
//   mem_wr          1 = write this cycle
//   io_buffer_full  UART buffer full; stalls writes to the I/O region
//   req_valid       request present; sampled only in IDLE
//   wr              1 = store, 0 = load
//   len             0 = byte, 1 = half, other values = word
//   addr            start byte address
//   value           store data, little-endian
//   ready           one-cycle completion pulse
//   result          load data, valid while ready = 1
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no request in flight; the ready pulse cycle is an IDLE cycle
// S_READ  | issuing byte addresses and capturing returned bytes
// S_WRITE | issuing one byte write per cycle

module mem_byte_responder #(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_HI  = 2'b11
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full,
    input  logic              req_valid,
    input  logic              wr,
    input  logic [2:0]        len,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       value,
    output logic              ready,
    output logic [31:0]       result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic [2:0]          n_q;        // bytes in this request (1, 2 or 4)
    logic [ADDR_W-1:0]   base_q;
    logic [31:0]         value_q;
    logic [2:0]          issue_q;    // index of the byte address driven now
    logic [2:0]          cap_q;      // number of read bytes captured so far
    logic                pend_q;     // mem_din holds a byte we asked for
    logic                stall_q;    // previous cycle had rdy_in low
    logic                ready_q;
    logic [31:0]         result_q;

    logic [2:0]          len_n;
    logic [2:0]          cur_idx;
    logic [ADDR_W-1:0]   cur_addr;
    logic                io_stall;
    logic                last_cap;
    logic                wr_last;

    logic [ADDR_W-1:0]   mem_a_c;
    logic [7:0]          mem_dout_c;
    logic                mem_wr_c;

    always_comb begin
        case (len)
            3'd0:    len_n = 3'd1;
            3'd1:    len_n = 3'd2;
            default: len_n = 3'd4;
        endcase
    end

    // After a pause the byte in flight was never captured, so the first
    // cycle back re-issues the lowest uncaptured address instead.
    assign cur_idx  = (state_q == S_READ && stall_q) ? cap_q : issue_q;
    assign cur_addr = base_q + ADDR_W'(cur_idx);

    assign io_stall = (state_q == S_WRITE) && (cur_addr[17:16] == IO_HI)
                      && io_buffer_full;

    assign last_cap = pend_q && !stall_q && ((cap_q + 3'd1) == n_q);
    assign wr_last  = (issue_q + 3'd1) == n_q;

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= S_IDLE;
        end else if (rdy_in) begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = wr ? S_WRITE : S_READ;
                end
            end
            S_READ: begin
                if (last_cap) begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                if (!io_stall && wr_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_a_c    = '0;
        mem_dout_c = 8'h00;
        mem_wr_c   = 1'b0;
        case (state_q)
            S_READ: begin
                if (stall_q || (issue_q < n_q)) begin
                    mem_a_c = cur_addr;
                end
            end
            S_WRITE: begin
                mem_a_c    = cur_addr;
                mem_dout_c = value_q[{issue_q[1:0], 3'b000} +: 8];
                mem_wr_c   = rdy_in && !io_stall;
            end
            default: ;
        endcase
    end

    assign mem_a    = mem_a_c;
    assign mem_dout = mem_dout_c;
    assign mem_wr   = mem_wr_c;
    assign ready    = ready_q;
    assign result   = result_q;

    // Request datapath: byte indices, capture and completion pulse
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            n_q      <= 3'd0;
            base_q   <= '0;
            value_q  <= 32'h0;
            issue_q  <= 3'd0;
            cap_q    <= 3'd0;
            pend_q   <= 1'b0;
            stall_q  <= 1'b0;
            ready_q  <= 1'b0;
            result_q <= 32'h0;
        end else begin
            stall_q <= !rdy_in;
            if (rdy_in) begin
                ready_q <= 1'b0;
                case (state_q)
                    S_IDLE: begin
                        if (req_valid) begin
                            n_q      <= len_n;
                            base_q   <= addr;
                            value_q  <= value;
                            issue_q  <= 3'd0;
                            cap_q    <= 3'd0;
                            pend_q   <= 1'b0;
                            result_q <= 32'h0;
                        end
                    end
                    S_READ: begin
                        if (stall_q) begin
                            issue_q <= cap_q + 3'd1;
                            pend_q  <= 1'b1;
                        end else begin
                            if (pend_q) begin
                                result_q[{cap_q[1:0], 3'b000} +: 8] <= mem_din;
                                cap_q <= cap_q + 3'd1;
                                if (last_cap) begin
                                    ready_q <= 1'b1;
                                end
                            end
                            if (issue_q < n_q) begin
                                issue_q <= issue_q + 3'd1;
                                pend_q  <= 1'b1;
                            end else begin
                                pend_q  <= 1'b0;
                            end
                        end
                    end
                    S_WRITE: begin
                        if (!io_stall) begin
                            issue_q <= issue_q + 3'd1;
                            if (wr_last) begin
                                ready_q <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_byte_responder.sv
module tb_mem_byte_responder;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;
    logic        req_valid;
    logic        wr;
    logic [2:0]  len;
    logic [31:0] addr;
    logic [31:0] value;
    logic        ready;
    logic [31:0] result;

    logic [7:0]  ram [0:65535];

    int total = 0;
    int bad   = 0;

    mem_byte_responder #(.ADDR_W(32), .IO_HI(2'b11)) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .rdy_in         (rdy_in),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full),
        .req_valid      (req_valid),
        .wr             (wr),
        .len            (len),
        .addr           (addr),
        .value          (value),
        .ready          (ready),
        .result         (result)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous byte memory: data for the address seen at an edge is
    // presented during the following cycle.
    always @(posedge clk_in) begin
        mem_din <= ram[mem_a[15:0]];
        if (mem_wr) ram[mem_a[15:0]] = mem_dout;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic request(input logic w, input logic [2:0] l, input logic [31:0] a,
                           input logic [31:0] v);
        req_valid = 1'b1;
        wr        = w;
        len       = l;
        addr      = a;
        value     = v;
    endtask

    initial begin
        logic seen_ready;
        rst_n_in       = 1'b0;
        rdy_in         = 1'b1;
        io_buffer_full = 1'b0;
        req_valid      = 1'b0;
        wr             = 1'b0;
        len            = 3'd0;
        addr           = 32'h0;
        value          = 32'h0;
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h0100] = 8'h11;
        ram[16'h0101] = 8'h22;
        ram[16'h0102] = 8'h33;
        ram[16'h0103] = 8'h44;
        ram[16'h0080] = 8'h80;
        ram[16'h0204] = 8'h5A;

        #1;
        check("rst mem_a",    mem_a,           32'h0);
        check("rst mem_wr",   {31'b0, mem_wr}, 32'h0);
        check("rst mem_dout", {24'b0, mem_dout}, 32'h0);
        check("rst ready",    {31'b0, ready},  32'h0);
        check("rst result",   result,          32'h0);
        tick();
        tick();
        rst_n_in = 1'b1;
        tick();

        // Word read at 0x100
        request(1'b0, 3'd2, 32'h100, 32'h0);
        tick();
        req_valid = 1'b0;
        check("rdw c0 a",  mem_a, 32'h100);
        check("rdw c0 wr", {31'b0, mem_wr}, 32'h0);
        tick(); check("rdw c1 a", mem_a, 32'h101);
        tick(); check("rdw c2 a", mem_a, 32'h102);
        tick(); check("rdw c3 a", mem_a, 32'h103);
        check("rdw c3 ready", {31'b0, ready}, 32'h0);
        tick(); check("rdw c4 ready", {31'b0, ready}, 32'h0);
        tick(); check("rdw c5 ready", {31'b0, ready}, 32'h1);
        check("rdw result", result, 32'h44332211);
        tick(); check("rdw pulse end", {31'b0, ready}, 32'h0);

        // Half write at 0x202
        request(1'b1, 3'd1, 32'h202, 32'hAABBCCDD);
        tick();
        req_valid = 1'b0;
        check("wrh c0 a",    mem_a, 32'h202);
        check("wrh c0 dout", {24'b0, mem_dout}, 32'hDD);
        check("wrh c0 wr",   {31'b0, mem_wr}, 32'h1);
        tick();
        check("wrh c1 a",    mem_a, 32'h203);
        check("wrh c1 dout", {24'b0, mem_dout}, 32'hCC);
        check("wrh c1 wr",   {31'b0, mem_wr}, 32'h1);
        tick();
        check("wrh c2 ready", {31'b0, ready}, 32'h1);
        check("wrh c2 wr",    {31'b0, mem_wr}, 32'h0);
        check("wrh ram202",   {24'b0, ram[16'h0202]}, 32'hDD);
        check("wrh ram203",   {24'b0, ram[16'h0203]}, 32'hCC);
        check("wrh ram204",   {24'b0, ram[16'h0204]}, 32'h5A);
        tick();

        // Byte read of 0x80, next word read presented early and held
        request(1'b0, 3'd0, 32'h80, 32'h0);
        tick();
        check("rdb c0 a", mem_a, 32'h80);
        request(1'b0, 3'd2, 32'h100, 32'h0);
        tick();
        tick();
        check("rdb ready",  {31'b0, ready}, 32'h1);
        check("rdb result", result, 32'h00000080);
        tick();
        req_valid = 1'b0;
        check("b2b c0 a",     mem_a, 32'h100);
        check("b2b c0 ready", {31'b0, ready}, 32'h0);
        tick(); tick(); tick(); tick();
        tick();
        check("b2b ready",  {31'b0, ready}, 32'h1);
        check("b2b result", result, 32'h44332211);
        tick();

        // Byte write into I/O space while the UART buffer is full
        io_buffer_full = 1'b1;
        request(1'b1, 3'd0, 32'h30000, 32'h12345677);
        tick();
        req_valid = 1'b0;
        check("io c0 wr", {31'b0, mem_wr}, 32'h0);
        tick(); check("io c1 wr", {31'b0, mem_wr}, 32'h0);
        tick(); check("io c2 wr", {31'b0, mem_wr}, 32'h0);
        check("io c2 a", mem_a, 32'h30000);
        tick();
        io_buffer_full = 1'b0;
        #1;
        check("io c3 wr",   {31'b0, mem_wr}, 32'h1);
        check("io c3 dout", {24'b0, mem_dout}, 32'h77);
        check("io c3 a",    mem_a, 32'h30000);
        tick();
        check("io ready", {31'b0, ready}, 32'h1);
        check("io wr off", {31'b0, mem_wr}, 32'h0);
        check("io ram",   {24'b0, ram[16'h0000]}, 32'h77);
        tick();

        // Word read paused for two cycles after byte 1 is captured
        request(1'b0, 3'd2, 32'h100, 32'h0);
        tick();
        req_valid = 1'b0;
        check("ps c0 a", mem_a, 32'h100);
        tick(); check("ps c1 a", mem_a, 32'h101);
        tick(); check("ps c2 a", mem_a, 32'h102);
        tick();
        rdy_in = 1'b0;
        #1;
        check("ps c3 wr",    {31'b0, mem_wr}, 32'h0);
        check("ps c3 ready", {31'b0, ready}, 32'h0);
        tick();
        check("ps c4 ready", {31'b0, ready}, 32'h0);
        tick();
        rdy_in = 1'b1;
        #1;
        check("ps refetch a", mem_a, 32'h102);
        tick(); check("ps c6 a", mem_a, 32'h103);
        check("ps c6 ready", {31'b0, ready}, 32'h0);
        tick(); check("ps c7 ready", {31'b0, ready}, 32'h0);
        tick(); check("ps ready", {31'b0, ready}, 32'h1);
        check("ps result", result, 32'h44332211);
        tick();

        // Word write, paused once, then aborted by reset
        request(1'b1, 3'd2, 32'h400, 32'h01020304);
        tick();
        req_valid = 1'b0;
        check("wa c0 a",    mem_a, 32'h400);
        check("wa c0 dout", {24'b0, mem_dout}, 32'h04);
        tick();
        rdy_in = 1'b0;
        #1;
        check("wa pause wr", {31'b0, mem_wr}, 32'h0);
        check("wa pause a",  mem_a, 32'h401);
        tick();
        rdy_in = 1'b1;
        #1;
        check("wa resume a",    mem_a, 32'h401);
        check("wa resume dout", {24'b0, mem_dout}, 32'h03);
        check("wa resume wr",   {31'b0, mem_wr}, 32'h1);
        tick();
        check("wa c3 a", mem_a, 32'h402);
        #2;
        rst_n_in = 1'b0;
        #1;
        check("ab mem_a",  mem_a, 32'h0);
        check("ab wr",     {31'b0, mem_wr}, 32'h0);
        check("ab dout",   {24'b0, mem_dout}, 32'h0);
        check("ab ready",  {31'b0, ready}, 32'h0);
        check("ab result", result, 32'h0);
        check("ab ram401", {24'b0, ram[16'h0401]}, 32'h03);
        tick();
        tick();
        rst_n_in = 1'b1;
        seen_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ready) seen_ready = 1'b1;
        end
        check("ab no ready", {31'b0, seen_ready}, 32'h0);

        request(1'b0, 3'd0, 32'h101, 32'h0);
        tick();
        req_valid = 1'b0;
        check("post c0 a", mem_a, 32'h101);
        tick();
        tick();
        check("post ready",  {31'b0, ready}, 32'h1);
        check("post result", result, 32'h00000022);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
